awg_delay_sequencer: RTL and testbench



---
 rtl/awg_delay_sequencer.sv | 147 ++++++++++++++
 tb/tb_awg_delay_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_delay_sequencer.sv
// Per-port delay-RAM playback sequencer: walks entries 1..N, counts each
// delay down and fires a one-cycle trigger tagged with the entry address.
module awg_delay_sequencer #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 24,
  parameter int LOOP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_W-1:0]     entry_count,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  input  logic [DATA_W-1:0]     ram_rd_data,
  output logic                  trig_out,
  output logic [ADDR_W-1:0]     trig_wave_id,
  output logic                  busy,
  output logic                  done,
  output logic [LOOP_CNT_W-1:0] loop_cnt
);

  typedef enum logic [2:0] {IDLE, READ, LOAD, COUNT, FIRE} state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       idx, idx_nxt;
  logic [ADDR_W-1:0]       n_lat, n_lat_nxt;
  logic [DATA_W-1:0]       cnt, cnt_nxt;
  logic [LOOP_CNT_W-1:0]   loop_cnt_nxt;
  logic                    rd_en_nxt;
  logic [ADDR_W-1:0]       rd_addr_nxt;
  logic                    trig_nxt;
  logic [ADDR_W-1:0]       wave_id_nxt;
  logic                    busy_nxt;
  logic                    done_nxt;

  // State and registered outputs; every output is the registered form of
  // the value computed for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      n_lat        <= '0;
      cnt          <= '0;
      loop_cnt     <= '0;
      ram_rd_en    <= 1'b0;
      ram_rd_addr  <= '0;
      trig_out     <= 1'b0;
      trig_wave_id <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      n_lat        <= n_lat_nxt;
      cnt          <= cnt_nxt;
      loop_cnt     <= loop_cnt_nxt;
      ram_rd_en    <= rd_en_nxt;
      ram_rd_addr  <= rd_addr_nxt;
      trig_out     <= trig_nxt;
      trig_wave_id <= wave_id_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    n_lat_nxt    = n_lat;
    cnt_nxt      = cnt;
    loop_cnt_nxt = loop_cnt;
    rd_en_nxt    = 1'b0;
    rd_addr_nxt  = ram_rd_addr;
    trig_nxt     = 1'b0;
    wave_id_nxt  = trig_wave_id;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    if (state != IDLE && stop) begin
      // Abort takes priority over every in-flight transition; a trigger
      // already registered for this cycle is still on the output.
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            if (entry_count != '0) begin
              n_lat_nxt    = entry_count;
              idx_nxt      = FIRST_IDX;
              loop_cnt_nxt = '0;
              busy_nxt     = 1'b1;
              rd_en_nxt    = 1'b1;
              rd_addr_nxt  = FIRST_IDX;
              state_nxt    = READ;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        READ: begin
          state_nxt = LOAD;
        end
        LOAD: begin
          cnt_nxt   = ram_rd_data;
          state_nxt = COUNT;
        end
        COUNT: begin
          if (cnt == '0) begin
            trig_nxt    = 1'b1;
            wave_id_nxt = idx;
            state_nxt   = FIRE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        FIRE: begin
          if (idx < n_lat) begin
            idx_nxt     = idx + 1'b1;
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = idx + 1'b1;
            state_nxt   = READ;
          end else begin
            if (loop_cnt != '1) loop_cnt_nxt = loop_cnt + 1'b1;
            if (loop_en) begin
              idx_nxt     = FIRST_IDX;
              rd_en_nxt   = 1'b1;
              rd_addr_nxt = FIRST_IDX;
              state_nxt   = READ;
            end else begin
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_awg_delay_sequencer.sv
// Scoreboard bench for awg_delay_sequencer: expected reads and triggers
// are derived from the delay table when a run starts, then matched
// against the DUT cycle by cycle.
module tb_awg_delay_sequencer;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 24;
  localparam int LCW    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stop, loop_en;
  logic [ADDR_W-1:0] entry_count;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              trig_out;
  logic [ADDR_W-1:0] trig_wave_id;
  logic              busy, done;
  logic [LCW-1:0]    loop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {int cyc; int id;} ev_t;
  ev_t rd_q[$];
  ev_t tr_q[$];

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  awg_delay_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOOP_CNT_W(LCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .entry_count(entry_count), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .trig_out(trig_out), .trig_wave_id(trig_wave_id),
    .busy(busy), .done(done), .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model: data valid the cycle after the strobe.
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  // Expected read/trigger events for entries first..last starting at read cycle r.
  task automatic push_pass(inout int r, input int first, input int last);
    int t;
    for (int k = first; k <= last; k++) begin
      rd_q.push_back('{r, k});
      t = r + 3 + int'(mem[k]);
      tr_q.push_back('{t, k});
      r = t + 1;
    end
  endtask

  // Issue start at relative cycle 0 and score the DUT against the queues.
  task automatic run_seq(input string name, input int budget, input int exp_done,
                         input int exp_loops, input int stop_at, input int restart_at,
                         input int drop_at, input int last_id, input bit with_stop);
    int t0, c, done_seen, trig_seen, pass_seen;
    ev_t e;
    done_seen = -1; trig_seen = 0; pass_seen = 0;
    @(negedge clk);
    t0 = cyc; start = 1'b1; stop = with_stop;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      c = cyc - t0;
      if (c == 1) begin start = 1'b0; stop = 1'b0; end
      if (ram_rd_en) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL %s rd_extra: read addr=%0d at cycle %0d, required no read", name, ram_rd_addr, c);
        end else begin
          e = rd_q.pop_front();
          if (e.cyc !== c || e.id !== int'(ram_rd_addr)) begin
            errors++;
            $display("FAIL %s rd: addr=%0d at cycle %0d, required addr=%0d at cycle %0d",
                     name, ram_rd_addr, c, e.id, e.cyc);
          end
        end
      end
      if (trig_out) begin
        checks++;
        trig_seen++;
        if (tr_q.size() == 0) begin
          errors++;
          $display("FAIL %s trig_extra: wave_id=%0d at cycle %0d, required no trigger", name, trig_wave_id, c);
        end else begin
          e = tr_q.pop_front();
          if (e.cyc !== c || e.id !== int'(trig_wave_id)) begin
            errors++;
            $display("FAIL %s trig: wave_id=%0d at cycle %0d, required wave_id=%0d at cycle %0d",
                     name, trig_wave_id, c, e.id, e.cyc);
          end
        end
        if (int'(trig_wave_id) == last_id) begin
          checks++;
          if (int'(loop_cnt) !== pass_seen) begin
            errors++;
            $display("FAIL %s loop_cnt_at_trig: got %0d, required %0d", name, loop_cnt, pass_seen);
          end
          pass_seen++;
        end
        if (trig_seen == drop_at) loop_en = 1'b0;
      end
      if (done) begin
        checks++;
        done_seen = c;
        if (c !== exp_done) begin
          errors++;
          $display("FAIL %s done: pulse at cycle %0d, required cycle %0d (-1 = none)", name, c, exp_done);
        end
      end
      if (stop_at >= 0 && c == stop_at) stop = 1'b1;
      if (stop_at >= 0 && c == stop_at + 1) begin
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_after_stop: got %b, required 0", name, busy);
        end
      end
      if (restart_at >= 0 && c == restart_at) begin start = 1'b1; entry_count = 11'd1; end
      if (restart_at >= 0 && c == restart_at + 1) start = 1'b0;
      if (done_seen >= 0 && c >= done_seen + 3) break;
    end
    checks++;
    if (rd_q.size() != 0 || tr_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: reads=%0d triggers=%0d outstanding, required 0 and 0",
               name, rd_q.size(), tr_q.size());
    end
    if (exp_done >= 0) begin
      checks++;
      if (done_seen < 0) begin
        errors++;
        $display("FAIL %s done_timeout: no done within %0d cycles, required at cycle %0d", name, budget, exp_done);
      end
    end
    if (exp_loops >= 0) begin
      checks++;
      if (int'(loop_cnt) !== exp_loops) begin
        errors++;
        $display("FAIL %s loop_cnt_final: got %0d, required %0d", name, loop_cnt, exp_loops);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_final: got %b, required 0", name, busy);
    end
    rd_q.delete();
    tr_q.delete();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; entry_count = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_rd_en, ram_rd_addr, trig_out, trig_wave_id, busy, done, loop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_init: en=%b addr=%0d trig=%b id=%0d busy=%b done=%b lc=%0d, required all 0",
               ram_rd_en, ram_rd_addr, trig_out, trig_wave_id, busy, done, loop_cnt);
    end
    rst_n = 1'b1;
    mem[1] = 24'd50; entry_count = 11'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ram_rd_addr !== 11'd1) begin
      errors++;
      $display("FAIL reset_pre_busy: busy=%b addr=%0d, required busy=1 addr=1", busy, ram_rd_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_rd_en, ram_rd_addr, trig_out, trig_wave_id, busy, done, loop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_async: en=%b addr=%0d trig=%b id=%0d busy=%b done=%b lc=%0d, required all 0",
               ram_rd_en, ram_rd_addr, trig_out, trig_wave_id, busy, done, loop_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ram_rd_en || busy || trig_out || done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_stays_idle: %0d active cycles after release, required 0", seen);
    end
  endtask

  task automatic test_basic();
    int r;
    mem[1] = 24'd5; mem[2] = 24'd0; mem[3] = 24'd10;
    entry_count = 11'd3; loop_en = 1'b0;
    r = 1;
    push_pass(r, 1, 3);
    run_seq("basic", 60, r, 1, -1, -1, -1, 3, 1'b0);
  endtask

  task automatic test_loop();
    int r;
    mem[1] = 24'd1; mem[2] = 24'd2;
    entry_count = 11'd2; loop_en = 1'b1;
    r = 1;
    for (int p = 0; p < 3; p++) push_pass(r, 1, 2);
    run_seq("loop", 100, r, 3, -1, -1, 5, 2, 1'b0);
    loop_en = 1'b0;
  endtask

  task automatic test_stop();
    int r;
    mem[1] = 24'd0; mem[2] = 24'd100;
    entry_count = 11'd2; loop_en = 1'b1;
    r = 1;
    push_pass(r, 1, 2);
    push_pass(r, 1, 1);
    rd_q.push_back('{r, 2});
    // COUNT for entry 2 begins two cycles after its read.
    run_seq("stop", 180, -1, 1, r + 2 + 20, -1, -1, 2, 1'b0);
    loop_en = 1'b0;
  endtask

  task automatic test_corner_starts();
    entry_count = 11'd0;
    run_seq("start_empty", 10, 1, -1, -1, -1, -1, 0, 1'b0);
    entry_count = 11'd3;
    run_seq("start_with_stop", 20, -1, -1, -1, -1, -1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int r;
    mem[1] = 24'd5; mem[2] = 24'd0; mem[3] = 24'd10;
    entry_count = 11'd3; loop_en = 1'b0;
    r = 1;
    push_pass(r, 1, 3);
    run_seq("start_while_busy", 60, r, 1, -1, 5, -1, 3, 1'b0);
  endtask

  task automatic test_last_address();
    int r;
    for (int k = 1; k < (1 << ADDR_W) - 1; k++) mem[k] = '0;
    mem[(1 << ADDR_W) - 1] = 24'd300;
    entry_count = '1; loop_en = 1'b0;
    r = 1;
    push_pass(r, 1, (1 << ADDR_W) - 1);
    run_seq("last_address", 9000, r, 1, -1, -1, -1, (1 << ADDR_W) - 1, 1'b0);
    checks++;
    if (ram_rd_addr !== 11'h7FF || trig_wave_id !== 11'h7FF) begin
      errors++;
      $display("FAIL last_address_hold: addr=%0d id=%0d, required 2047 and 2047", ram_rd_addr, trig_wave_id);
    end
  endtask

  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = '0;
    ram_rd_data = '0;
    test_reset();
    test_basic();
    test_loop();
    test_stop();
    test_corner_starts();
    test_back_to_back();
    test_last_address();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
